// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM command port between two requesters,
// locking address/data pairs to one owner and routing read bytes back to it.
module ram_port_arbiter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    output logic [7:0] req0_rdata,
    output logic       req0_rvalid,
    input  logic [9:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] req1_rdata,
    output logic       req1_rvalid,
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    output logic       owner,
    output logic       busy,
    output logic       timeout
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, LOCK, WAIT_RD} state_e;

    state_e          state_q, acc_state_d;
    logic            owner_q, last_q, win, acc0, acc1, acc, expire;
    logic [TW-1:0]   timer_q, timer_d;
    logic [9:0]      ram_din_q, acc_data;
    logic            ram_rx_valid_q, rvalid0_q, rvalid1_q, timeout_q;
    logic [7:0]      rdata0_q, rdata1_q;

    // In IDLE a tie goes to the port that did not win last; in LOCK only the owner may talk.
    always_comb begin
        win         = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        req0_ready  = (state_q == IDLE) ? (req0_valid && !win) : (state_q == LOCK) && !owner_q;
        req1_ready  = (state_q == IDLE) ? (req1_valid && win) : (state_q == LOCK) && owner_q;
        acc0        = req0_valid && req0_ready;
        acc1        = req1_valid && req1_ready;
        acc         = acc0 || acc1;
        acc_data    = acc1 ? req1_data : req0_data;
        acc_state_d = (acc_data[9:8] == 2'b01) ? IDLE : (acc_data[9:8] == 2'b11) ? WAIT_RD : LOCK;
        timer_d     = timer_q + TW'(1);
        expire      = (timer_d == TW'(TIMEOUT_CYC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            last_q         <= 1'b1;
            timer_q        <= '0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
            rvalid0_q      <= 1'b0;
            rvalid1_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            ram_rx_valid_q <= acc;
            if (acc) ram_din_q <= acc_data;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (acc) begin
                        owner_q <= acc1;
                        last_q  <= acc1;
                        state_q <= acc_state_d;
                    end
                end
                LOCK: begin
                    if (acc) begin
                        state_q <= acc_state_d;
                        timer_q <= '0;
                    end else if (expire) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                        timer_q   <= '0;
                    end else timer_q <= timer_d;
                end
                WAIT_RD: begin
                    if (ram_tx_valid) begin
                        if (owner_q) begin
                            rdata1_q  <= ram_dout;
                            rvalid1_q <= 1'b1;
                        end else begin
                            rdata0_q  <= ram_dout;
                            rvalid0_q <= 1'b1;
                        end
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (expire) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                        timer_q   <= '0;
                    end else timer_q <= timer_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_din      = ram_din_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign req0_rdata   = rdata0_q;
    assign req0_rvalid  = rvalid0_q;
    assign req1_rdata   = rdata1_q;
    assign req1_rvalid  = rvalid1_q;
    assign owner        = owner_q;
    assign busy         = (state_q != IDLE);
    assign timeout      = timeout_q;
endmodule
